sar_adc_seq: RTL and testbench
==============================

Name: sar_adc_seq

Overview:
- Digital SAR sequencer directly upstream of the analog top's comparator/DAC path.
- Scans a mask of analog channels. For each enabled channel it drives a one-hot comparator mux select, waits for settling, and holds the sample.
- It then runs a binary-search conversion on the DAC code while sampling the comparator output, and publishes one result per channel to the register/PD logic.

Parameters:
NCH, 8, number of analog channels (one-hot select width)
DW, 10, DAC code / result width
SW, 4, width of settle and bit-time counters
CW, clog2(NCH) (derived localparam), channel index width

Ports:
clk  input  1  system clock
srstz  input  1  synchronous active-low reset
start  input  1  one-cycle request to begin a scan; honoured only in IDLE
abort  input  1  terminate any activity; return to IDLE next cycle
cont  input  1  1 = rescan continuously; sampled at end of each scan
ch_en  input  NCH  channel enable mask; bit k enables channel k
settle_cyc  input  SW  mux settle time, in clk cycles
bit_cyc  input  SW  per-bit DAC settle time; values below 2 are treated as 2
comp_o  input  1  asynchronous comparator output; 1 = input above DAC
dac0  output  DW  DAC code to analog
cmp_sel  output  NCH  one-hot comparator mux select
ad_rst  output  1  analog sample/hold reset, active high
ad_hold  output  1  analog hold, active high
busy  output  1  high in any state other than IDLE
res_vld  output  1  one-cycle strobe: result valid
res_ch  output  CW  channel index of the result
res_dat  output  DW  conversion result
done  output  1  one-cycle strobe at the end of a non-continuous scan

Behaviour:
- Reset (srstz=0 at a clk edge):
  - State = IDLE.
  - dac0=0, cmp_sel=0, ad_rst=1, ad_hold=0, busy=0, res_vld=0, res_ch=0, res_dat=0, done=0.
  - Synchronizer flops cleared.
  - Reset mid-conversion discards all work; no strobes are issued.
- comp_o passes through a 2-flop synchronizer; every decision uses the synchronized value.
- IDLE:
  - ad_rst=1, cmp_sel=0, dac0=0.
  - start=1 with ch_en!=0: latch ch_en into a scan mask, pick the lowest set bit as the current channel, go to SEL.
  - start=1 with ch_en=0: ignored; no done.
- SEL:
  - cmp_sel is one-hot on the current channel, ad_rst=0.
  - Counts settle_cyc+1 cycles, then goes to HOLD.
- HOLD:
  - ad_hold=1 for 2 cycles, then CONV.
  - ad_hold stays 1 through CONV and drops on entering STORE.
- CONV, bits i = DW-1 down to 0:
  - Trial code = accumulated code with bit i set; drive dac0 = trial.
  - Wait max(bit_cyc,2)+1 cycles, then sample synchronized comp_o.
  - 1 keeps bit i; 0 clears it.
  - The MSB trial is 2^(DW-1).
  - Total CONV length = DW*(max(bit_cyc,2)+1) cycles.
- STORE (1 cycle):
  - res_dat = final code, res_ch = current index, res_vld=1.
  - res_dat and res_ch hold until the next STORE.
  - dac0 returns to 0; cmp_sel=0.
- NEXT (1 cycle):
  - If a higher set bit exists in the latched mask: that bit becomes the current channel; go to SEL.
  - Otherwise, if cont=1: re-latch ch_en. If it is non-zero, select its lowest set bit and go to SEL; if it is zero, go to IDLE with no done.
  - Otherwise: done=1 for this cycle; go to IDLE.
- ch_en changes mid-scan have no effect until the next re-latch.
- abort=1 in any state: next state is IDLE with reset-state outputs; no res_vld, no done. abort has priority over start in the same cycle.
- start while busy is ignored.
- Boundary codes:
  - Input below code 1: result 0.
  - Input above full scale: result 2^DW-1.

Test Plan:
- Single channel, ch_en=8'h04, settle_cyc=3, bit_cyc=2, comp_o modelled as input 0x2A5 > dac0 → cmp_sel=8'h04, one res_vld with res_ch=2, res_dat=10'h2A5, then done one cycle later. Strobe lands 4+2+30+1 cycles after SEL entry.
- Multi-channel, ch_en=8'h81, per-channel inputs 0x000 and 0x3FF → results in order ch0=0x000, ch7=0x3FF; cmp_sel is never multi-hot; exactly one done.
- Continuous: cont=1, ch_en=8'h02 → repeated res_vld on ch1. Clearing cont → done after the current result, then IDLE.
- abort asserted mid-CONV at bit 5 → next cycle busy=0, dac0=0, cmp_sel=0, ad_hold=0, ad_rst=1; no res_vld, no done.
- srstz=0 during HOLD → all outputs at reset values next cycle. start with ch_en=0 → busy stays 0.
- bit_cyc=0 → per-bit time equals bit_cyc=2, i.e. 3 cycles per bit; result correct for input 0x155.

Source files
------------

// File: rtl/sar_adc_seq.sv
// Successive-approximation sequencer: scans an enabled channel mask and drives the
// comparator mux, sample/hold and DAC code, publishing one result per channel.
module sar_adc_seq #(
  parameter int unsigned NCH = 8,
  parameter int unsigned DW  = 10,
  parameter int unsigned SW  = 4,
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          srstz,
  input  logic          start,
  input  logic          abort,
  input  logic          cont,
  input  logic [NCH-1:0] ch_en,
  input  logic [SW-1:0]  settle_cyc,
  input  logic [SW-1:0]  bit_cyc,
  input  logic          comp_o,
  output logic [DW-1:0]  dac0,
  output logic [NCH-1:0] cmp_sel,
  output logic          ad_rst,
  output logic          ad_hold,
  output logic          busy,
  output logic          res_vld,
  output logic [CW-1:0]  res_ch,
  output logic [DW-1:0]  res_dat,
  output logic          done
);

  localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_HOLD, S_CONV, S_STORE, S_NEXT
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cur_q, cur_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [DW-1:0]  code_q, code_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [DW-1:0]  res_dat_q, res_dat_d;
  logic [CW-1:0]  res_ch_q, res_ch_d;
  logic           sync1_q, sync2_q;

  logic [NCH-1:0] sel_oh;
  logic [DW-1:0]  trial;
  logic [DW-1:0]  decided;
  logic [SW-1:0]  bit_time;

  function automatic logic [CW-1:0] lowest(input logic [NCH-1:0] m);
    logic found;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (m[i] && !found) begin
        lowest = CW'(i);
        found  = 1'b1;
      end
    end
  endfunction

  assign sel_oh   = NCH'(1) << cur_q;
  assign trial    = code_q | (DW'(1) << bit_q);
  assign decided  = sync2_q ? trial : code_q;
  assign bit_time = (bit_cyc < SW'(2)) ? SW'(2) : bit_cyc;
  assign res_dat  = res_dat_q;
  assign res_ch   = res_ch_q;

  always_ff @(posedge clk) begin
    if (!srstz) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cur_q     <= '0;
      mask_q    <= '0;
      code_q    <= '0;
      bit_q     <= '0;
      res_dat_q <= '0;
      res_ch_q  <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      mask_q    <= mask_d;
      code_q    <= code_d;
      bit_q     <= bit_d;
      res_dat_q <= res_dat_d;
      res_ch_q  <= res_ch_d;
      sync1_q   <= comp_o;
      sync2_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    mask_d    = mask_q;
    code_d    = code_q;
    bit_d     = bit_q;
    res_dat_d = res_dat_q;
    res_ch_d  = res_ch_q;
    dac0      = '0;
    cmp_sel   = '0;
    ad_rst    = 1'b0;
    ad_hold   = 1'b0;
    busy      = 1'b1;
    res_vld   = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy   = 1'b0;
        ad_rst = 1'b1;
        if (start && |ch_en) begin
          mask_d  = ch_en;
          cur_d   = lowest(ch_en);
          cnt_d   = '0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        cmp_sel = sel_oh;
        if (cnt_q == settle_cyc) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        cmp_sel = sel_oh;
        ad_hold = 1'b1;
        if (cnt_q == SW'(1)) begin
          cnt_d   = '0;
          code_d  = '0;
          bit_d   = BW'(DW - 1);
          state_d = S_CONV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONV: begin
        cmp_sel = sel_oh;
        ad_hold = 1'b1;
        dac0    = trial;
        if (cnt_q == bit_time) begin
          cnt_d  = '0;
          code_d = decided;
          if (bit_q == '0) begin
            res_dat_d = decided;
            res_ch_d  = cur_q;
            state_d   = S_STORE;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STORE: begin
        res_vld = 1'b1;
        // Retire the finished channel so NEXT only sees higher-numbered ones.
        mask_d  = mask_q & ~sel_oh;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        cnt_d = '0;
        if (|mask_q) begin
          cur_d   = lowest(mask_q);
          state_d = S_SEL;
        end else if (cont) begin
          mask_d = ch_en;
          if (|ch_en) begin
            cur_d   = lowest(ch_en);
            state_d = S_SEL;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      cur_d     = cur_q;
      mask_d    = mask_q;
      res_dat_d = res_dat_q;
      res_ch_d  = res_ch_q;
      res_vld   = 1'b0;
      done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_adc_seq.sv
// Directed bench for sar_adc_seq; analog inputs are modelled in half-LSB units so a
// code-k input sits midway between DAC codes k and k+1.
module tb_sar_adc_seq;

  localparam int unsigned NCH = 8;
  localparam int unsigned DW  = 10;
  localparam int unsigned SW  = 4;
  localparam int unsigned CW  = 3;

  logic           clk = 1'b0;
  logic           srstz, start, abort, cont;
  logic [NCH-1:0] ch_en;
  logic [SW-1:0]  settle_cyc, bit_cyc;
  logic           comp_o;
  logic [DW-1:0]  dac0;
  logic [NCH-1:0] cmp_sel;
  logic           ad_rst, ad_hold, busy, res_vld, done;
  logic [CW-1:0]  res_ch;
  logic [DW-1:0]  res_dat;

  int ana [NCH];
  int passed = 0;
  int total  = 0;
  int vld_cnt = 0;
  int done_cnt = 0;
  int multihot_cnt = 0;
  int n, k, v0, d0, m0;

  sar_adc_seq #(.NCH(NCH), .DW(DW), .SW(SW)) dut (
    .clk(clk), .srstz(srstz), .start(start), .abort(abort), .cont(cont),
    .ch_en(ch_en), .settle_cyc(settle_cyc), .bit_cyc(bit_cyc), .comp_o(comp_o),
    .dac0(dac0), .cmp_sel(cmp_sel), .ad_rst(ad_rst), .ad_hold(ad_hold),
    .busy(busy), .res_vld(res_vld), .res_ch(res_ch), .res_dat(res_dat), .done(done)
  );

  always #5 clk = ~clk;

  // Analog mux + comparator: 1 when the selected input exceeds the DAC level.
  always_comb begin
    comp_o = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (cmp_sel[i]) comp_o = (ana[i] > 2 * int'(dac0));
  end

  always @(posedge clk) begin
    if (res_vld === 1'b1) vld_cnt++;
    if (done === 1'b1) done_cnt++;
    if ($countones(cmp_sel) > 1) multihot_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_dac0"}, 32'(dac0), 0);
    chk({tag, "_sel"}, 32'(cmp_sel), 0);
    chk({tag, "_hold"}, 32'(ad_hold), 0);
    chk({tag, "_rst"}, 32'(ad_rst), 1);
    chk({tag, "_vld"}, 32'(res_vld), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic wait_vld(input int budget, output int cyc);
    cyc = 0;
    while (res_vld !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("vld_timeout", 32'(res_vld), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    srstz = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
    ch_en = '0; settle_cyc = 4'd3; bit_cyc = 4'd2;
    for (int i = 0; i < NCH; i++) ana[i] = 0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    chk("reset_res_ch", 32'(res_ch), 0);
    chk("reset_res_dat", 32'(res_dat), 0);
    srstz = 1'b1;
    @(negedge clk);

    // Single channel 2, input 0x2A5
    ch_en = 8'h04; ana[2] = 2 * 'h2A5 + 1;
    v0 = vld_cnt; d0 = done_cnt; m0 = multihot_cnt;
    pulse_start();
    n = 1;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_sel", 32'(cmp_sel), 'h04);
    chk("t1_rst", 32'(ad_rst), 0);
    while (res_vld !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 5) chk("t1_hold_on", 32'(ad_hold), 1);
      if (n == 7) chk("t1_msb_trial", 32'(dac0), 'h200);
      if (n == 36) chk("t1_hold_conv", 32'(ad_hold), 1);
    end
    chk("t1_latency", 32'(n), 37);
    chk("t1_res_ch", 32'(res_ch), 2);
    chk("t1_res_dat", 32'(res_dat), 'h2A5);
    chk("t1_store_dac", 32'(dac0), 0);
    chk("t1_store_hold", 32'(ad_hold), 0);
    @(negedge clk);
    chk("t1_done", 32'(done), 1);
    @(negedge clk);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_vld_count", 32'(vld_cnt - v0), 1);
    chk("t1_done_count", 32'(done_cnt - d0), 1);
    chk("t1_res_hold", 32'(res_dat), 'h2A5);

    // Two channels: ch0 below code 1, ch7 above full scale
    ch_en = 8'h81; ana[0] = 0; ana[7] = 4000;
    v0 = vld_cnt; d0 = done_cnt;
    pulse_start();
    wait_vld(100, k);
    chk("t2_ch_a", 32'(res_ch), 0);
    chk("t2_dat_a", 32'(res_dat), 'h000);
    @(negedge clk);
    wait_vld(100, k);
    chk("t2_ch_b", 32'(res_ch), 7);
    chk("t2_dat_b", 32'(res_dat), 'h3FF);
    repeat (3) @(negedge clk);
    chk("t2_idle", 32'(busy), 0);
    chk("t2_vld_count", 32'(vld_cnt - v0), 2);
    chk("t2_done_count", 32'(done_cnt - d0), 1);
    chk("t2_multihot", 32'(multihot_cnt - m0), 0);

    // Continuous scan on ch1, then cont cleared
    cont = 1'b1; ch_en = 8'h02; ana[1] = 2 * 'h155 + 1;
    v0 = vld_cnt; d0 = done_cnt;
    pulse_start();
    wait_vld(100, k);
    chk("t3_ch_a", 32'(res_ch), 1);
    chk("t3_dat_a", 32'(res_dat), 'h155);
    @(negedge clk);
    chk("t3_no_done", 32'(done), 0);
    wait_vld(100, k);
    chk("t3_ch_b", 32'(res_ch), 1);
    cont = 1'b0;
    @(negedge clk);
    chk("t3_done", 32'(done), 1);
    @(negedge clk);
    chk("t3_idle", 32'(busy), 0);
    chk("t3_vld_count", 32'(vld_cnt - v0), 2);
    chk("t3_done_count", 32'(done_cnt - d0), 1);

    // Abort during bit 5 of CONV
    ch_en = 8'h01; ana[0] = 2 * 'h2A5 + 1;
    v0 = vld_cnt; d0 = done_cnt;
    pulse_start();
    repeat (19) @(negedge clk);
    chk("t4_bit5_trial", 32'(dac0), 'h2A0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_reset_outs("t4_abort");
    repeat (50) @(negedge clk);
    chk("t4_vld_count", 32'(vld_cnt - v0), 0);
    chk("t4_done_count", 32'(done_cnt - d0), 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t4_abort_prio", 32'(busy), 0);

    // Reset during HOLD, then start with empty mask
    v0 = vld_cnt; d0 = done_cnt;
    pulse_start();
    repeat (4) @(negedge clk);
    chk("t5_in_hold", 32'(ad_hold), 1);
    srstz = 1'b0;
    @(negedge clk);
    srstz = 1'b1;
    chk_reset_outs("t5_reset");
    chk("t5_res_ch", 32'(res_ch), 0);
    chk("t5_res_dat", 32'(res_dat), 0);
    ch_en = '0;
    pulse_start();
    chk("t5_empty_start", 32'(busy), 0);
    repeat (45) @(negedge clk);
    chk("t5_vld_count", 32'(vld_cnt - v0), 0);
    chk("t5_done_count", 32'(done_cnt - d0), 0);

    // bit_cyc=0 behaves like 2; settle_cyc=0 gives one SEL cycle
    bit_cyc = 4'd0; settle_cyc = 4'd0; ch_en = 8'h08; ana[3] = 2 * 'h155 + 1;
    pulse_start();
    wait_vld(100, k);
    chk("t6_latency", 32'(k + 1), 34);
    chk("t6_res_ch", 32'(res_ch), 3);
    chk("t6_res_dat", 32'(res_dat), 'h155);
    repeat (3) @(negedge clk);
    chk("t6_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
